// File: rtl/ama_riscv_pkg.sv
// Shared types for the store buffer: entry layout and default depth.
package ama_riscv_pkg;

  localparam int unsigned SB_AW        = 32;
  localparam int unsigned SB_DEPTH_DEF = 4;

  // One posted write; waddr is the byte address with bits [1:0] dropped.
  typedef struct packed {
    logic [SB_AW-3:0] waddr;
    logic [31:0]      data;
    logic [3:0]       mask;
  } sb_entry_t;

endpackage

// File: rtl/ama_riscv_store_buffer_if.sv
// Store path, DMEM write port, load check and fence signals of the store buffer.
// AMA_RISCV_STORE_BUF_FWD_EN adds the load-forwarding result signals.
interface ama_riscv_store_buffer_if #(
  parameter int unsigned AW = 32
);
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic [3:0]    st_mask;
  logic          mem_req;
  logic          mem_ack;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;
  logic          ld_chk_valid;
  logic [AW-1:0] ld_chk_addr;
  logic          ld_hazard;
  logic          fence;
  logic          fence_busy;
  logic          empty;
`ifdef AMA_RISCV_STORE_BUF_FWD_EN
  logic          ld_fwd_hit;
  logic [31:0]   ld_fwd_data;

  modport master (
    output st_valid, st_addr, st_data, st_mask, mem_ack, ld_chk_valid, ld_chk_addr, fence,
    input  st_ready, mem_req, mem_addr, mem_wdata, mem_wmask, ld_hazard, fence_busy, empty,
    input  ld_fwd_hit, ld_fwd_data
  );
  modport slave (
    input  st_valid, st_addr, st_data, st_mask, mem_ack, ld_chk_valid, ld_chk_addr, fence,
    output st_ready, mem_req, mem_addr, mem_wdata, mem_wmask, ld_hazard, fence_busy, empty,
    output ld_fwd_hit, ld_fwd_data
  );
`else
  modport master (
    output st_valid, st_addr, st_data, st_mask, mem_ack, ld_chk_valid, ld_chk_addr, fence,
    input  st_ready, mem_req, mem_addr, mem_wdata, mem_wmask, ld_hazard, fence_busy, empty
  );
  modport slave (
    input  st_valid, st_addr, st_data, st_mask, mem_ack, ld_chk_valid, ld_chk_addr, fence,
    output st_ready, mem_req, mem_addr, mem_wdata, mem_wmask, ld_hazard, fence_busy, empty
  );
`endif
endinterface

// File: rtl/ama_riscv_sb_fifo.sv
// DEPTH-entry ring of store-buffer entries with per-slot valid bits.
// All slots are exposed so the owner can run an address match across them.
module ama_riscv_sb_fifo
  import ama_riscv_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH_DEF,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  sb_entry_t             push_entry,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output sb_entry_t             head,
  output sb_entry_t [DEPTH-1:0] entries,
  output logic [DEPTH-1:0]      valid,
  output logic [PW-1:0]         rd_ptr
);

  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = entries[rd_ptr];

  // Pointers, occupancy and valid bits; pointers wrap since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage; qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) entries[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/ama_riscv_store_buffer.sv
// Posted-write buffer between the MEM-stage store path and the DMEM write port.
// Stores retire in order over mem_req/mem_ack; loads hitting a pending store stall.
// AMA_RISCV_STORE_BUF_FWD_EN: forward full-word matches instead of stalling.
module ama_riscv_store_buffer
  import ama_riscv_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH_DEF,
  // Entry layout comes from the package, so AW must equal SB_AW.
  parameter int unsigned AW    = SB_AW
) (
  input logic                       clk,
  input logic                       rst,
  ama_riscv_store_buffer_if.slave   bus
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic                  full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  sb_entry_t             push_entry;
  sb_entry_t             head;
  sb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         idx;
  logic                  match;
  sb_entry_t             youngest;

  // A zero mask is handshaken but nothing is stored.
  assign push = bus.st_valid && !full && (bus.st_mask != 4'h0);
  assign pop  = !fifo_empty && bus.mem_ack;

  assign push_entry = '{waddr: bus.st_addr[AW-1:2], data: bus.st_data, mask: bus.st_mask};

  ama_riscv_sb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .full       (full),
    .empty      (fifo_empty),
    .head       (head),
    .entries    (entries),
    .valid      (valid),
    .rd_ptr     (rd_ptr)
  );

  assign bus.st_ready   = !full;
  assign bus.empty      = fifo_empty;
  assign bus.mem_req    = !fifo_empty;
  assign bus.mem_addr   = {head.waddr, 2'b00};
  assign bus.mem_wdata  = head.data;
  assign bus.mem_wmask  = head.mask;
  assign bus.fence_busy = bus.fence && !fifo_empty;

  // Scan oldest to youngest so the last hit is the youngest matching entry.
  always_comb begin
    match    = 1'b0;
    youngest = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (valid[idx] && (entries[idx].waddr == bus.ld_chk_addr[AW-1:2])) begin
        match    = 1'b1;
        youngest = entries[idx];
      end
    end
  end

`ifdef AMA_RISCV_STORE_BUF_FWD_EN
  // Only a full-word youngest match can be forwarded; anything partial stalls.
  always_comb begin
    bus.ld_fwd_hit  = bus.ld_chk_valid && match && (youngest.mask == 4'hF);
    bus.ld_fwd_data = youngest.data;
    bus.ld_hazard   = bus.ld_chk_valid && match && (youngest.mask != 4'hF);
  end
`else
  // Any pending store to the same word stalls the load.
  always_comb begin
    bus.ld_hazard = bus.ld_chk_valid && match;
  end
`endif

endmodule
